// File: rtl/y86_execute.sv
// Y86-64 execute stage: valE ALU, ZF/SF/OF condition codes, jXX/cmovXX condition (optional cc port: EXEC_CC_PORT_EN).
// Latency 1 cycle from flag2 to valE/cnd/flag3.
// No backpressure: a new flag2 beat is accepted every cycle.
module y86_execute #(
  parameter int W    = 64,
  parameter int STEP = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flag2,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valC,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  output logic [W-1:0] valE,
  output logic         cnd,
`ifdef EXEC_CC_PORT_EN
  output logic [2:0]   cc,
`endif
  output logic         flag3
);

  logic         zf, sf, of;
  logic         legal;
  logic         cond_ok;
  logic         is_branch;
  logic         cc_upd;
  logic [W-1:0] op_res;
  logic         op_of;
  logic [W-1:0] alu;

  always_comb begin
    is_branch = (icode == 4'h2) || (icode == 4'h7);
    legal = 1'b1;
    if (icode > 4'hB)
      legal = 1'b0;
    else if ((icode == 4'h6) && (ifun > 4'h3))
      legal = 1'b0;
    else if (is_branch && (ifun > 4'h6))
      legal = 1'b0;
  end

  // OPq result and signed overflow
  always_comb begin
    op_res = '0;
    op_of  = 1'b0;
    case (ifun[1:0])
      2'd0: begin
        op_res = valB + valA;
        op_of  = (valA[W-1] == valB[W-1]) && (op_res[W-1] != valA[W-1]);
      end
      2'd1: begin
        op_res = valB - valA;
        op_of  = (valA[W-1] != valB[W-1]) && (op_res[W-1] != valB[W-1]);
      end
      2'd2:    op_res = valB & valA;
      default: op_res = valB ^ valA;
    endcase
  end

  always_comb begin
    case (ifun)
      4'h0:    cond_ok = 1'b1;
      4'h1:    cond_ok = (sf ^ of) | zf;
      4'h2:    cond_ok = sf ^ of;
      4'h3:    cond_ok = zf;
      4'h4:    cond_ok = ~zf;
      4'h5:    cond_ok = ~(sf ^ of);
      4'h6:    cond_ok = ~(sf ^ of) & ~zf;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (icode)
      4'h2:       alu = valA;
      4'h3:       alu = valC;
      4'h4, 4'h5: alu = valB + valC;
      4'h6:       alu = op_res;
      4'h8, 4'hA: alu = valB - W'(STEP);
      4'h9, 4'hB: alu = valB + W'(STEP);
      default:    alu = '0;
    endcase
  end

  assign cc_upd = flag2 && legal && (icode == 4'h6);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valE  <= '0;
      cnd   <= 1'b0;
      flag3 <= 1'b0;
      zf    <= 1'b0;
      sf    <= 1'b0;
      of    <= 1'b0;
    end else begin
      flag3 <= flag2 && legal;
      if (flag2) begin
        valE <= legal ? alu : '0;
        // cnd sees the CC from before this instruction's own update
        cnd  <= legal && is_branch && cond_ok;
      end
      if (cc_upd) begin
        zf <= (op_res == '0);
        sf <= op_res[W-1];
        of <= op_of;
      end
    end
  end

`ifdef EXEC_CC_PORT_EN
  assign cc = {zf, sf, of};
`endif

endmodule

// File: tb/tb_y86_execute.sv
// Bench for y86_execute: directed cases plus random back-to-back traffic against a behavioural model.
module tb_y86_execute;
  localparam int W    = 64;
  localparam int STEP = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flag2;
  logic [3:0]   icode, ifun;
  logic [W-1:0] valC, valA, valB;
  logic [W-1:0] valE;
  logic         cnd, flag3;
`ifdef EXEC_CC_PORT_EN
  logic [2:0]   cc;
`endif

  y86_execute #(.W(W), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .flag2(flag2), .icode(icode), .ifun(ifun),
    .valC(valC), .valA(valA), .valB(valB), .valE(valE), .cnd(cnd),
`ifdef EXEC_CC_PORT_EN
    .cc(cc),
`endif
    .flag3(flag3)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0] m_vale = '0;
  logic         m_cnd = 1'b0, m_flag3 = 1'b0;
  logic         m_zf = 1'b0, m_sf = 1'b0, m_of = 1'b0;
  logic signed [W+1:0] smax, smin;

  // Drive one cycle, advance the model, return 1ns after the capturing edge.
  task automatic apply(input logic r, input logic f2, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic legal, c_ok;
    logic signed [W+1:0] ex;
    @(negedge clk);
    rst_n = r; flag2 = f2; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    legal = (ic <= 4'd11) && !(ic == 4'd6 && fn > 4'd3) &&
            !((ic == 4'd2 || ic == 4'd7) && fn > 4'd6);
    case (fn)
      4'd0:    c_ok = 1'b1;
      4'd1:    c_ok = (m_sf != m_of) || m_zf;
      4'd2:    c_ok = (m_sf != m_of);
      4'd3:    c_ok = m_zf;
      4'd4:    c_ok = !m_zf;
      4'd5:    c_ok = (m_sf == m_of);
      4'd6:    c_ok = (m_sf == m_of) && !m_zf;
      default: c_ok = 1'b0;
    endcase
    if (!r) begin
      m_vale = '0; m_cnd = 0; m_flag3 = 0; m_zf = 0; m_sf = 0; m_of = 0;
    end else if (!f2) begin
      m_flag3 = 0;
    end else if (!legal) begin
      m_vale = '0; m_cnd = 0; m_flag3 = 0;
    end else begin
      m_flag3 = 1;
      m_cnd = (ic == 4'd2 || ic == 4'd7) ? c_ok : 1'b0;
      case (ic)
        4'd2:        m_vale = a;
        4'd3:        m_vale = c;
        4'd4, 4'd5:  m_vale = b + c;
        4'd8, 4'd10: m_vale = b - W'(STEP);
        4'd9, 4'd11: m_vale = b + W'(STEP);
        4'd6: begin
          // exact signed result, then range-check for overflow
          case (fn)
            4'd0:    ex = $signed(b) + $signed(a);
            4'd1:    ex = $signed(b) - $signed(a);
            4'd2:    ex = $signed(b & a);
            default: ex = $signed(b ^ a);
          endcase
          m_vale = ex[W-1:0];
          m_of = (ex > smax) || (ex < smin);
          m_zf = (m_vale == '0);
          m_sf = ($signed(m_vale) < 0);
        end
        default: m_vale = '0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(0, 1, 4'd6, 4'd0, 64'd1, 64'd1, 64'd0);
    checks += 3;
    if (valE !== '0)   begin errors++; $display("FAIL reset_valE got=%h exp=0", valE); end
    if (cnd !== 1'b0)  begin errors++; $display("FAIL reset_cnd got=%b exp=0", cnd); end
    if (flag3 !== 1'b0) begin errors++; $display("FAIL reset_flag3 got=%b exp=0", flag3); end
  endtask

  task automatic test_opq();
    logic [3:0]   ic[6] = '{4'd6, 4'd6, 4'd7, 4'd6, 4'd2, 4'd6};
    logic [3:0]   fn[6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd5, 4'd2};
    logic [W-1:0] a[6]  = '{64'd4, 64'd4, 64'd0, 64'd1, 64'h55, 64'hF0F0};
    logic [W-1:0] b[6]  = '{64'd2, 64'd2, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h0FF0};
    logic [W-1:0] ev[6] = '{64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'h8000_0000_0000_0000, 64'h55, 64'h00F0};
    logic         ec[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(1, 1, ic[i], fn[i], a[i], b[i], 64'd0);
      checks += 3;
      if (valE !== ev[i]) begin errors++; $display("FAIL opq_valE[%0d] got=%h exp=%h", i, valE, ev[i]); end
      if (cnd !== ec[i])  begin errors++; $display("FAIL opq_cnd[%0d] got=%b exp=%b", i, cnd, ec[i]); end
      if (flag3 !== 1'b1) begin errors++; $display("FAIL opq_flag3[%0d] got=%b exp=1", i, flag3); end
    end
  endtask

  task automatic test_stack();
    logic [3:0]   ic[4] = '{4'd10, 4'd11, 4'd5, 4'd8};
    logic [W-1:0] b[4]  = '{64'h100, 64'h100, 64'h10, 64'h0};
    logic [W-1:0] ev[4] = '{64'hF8, 64'h108, 64'h18, 64'hFFFF_FFFF_FFFF_FFF8};
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, ic[i], 4'd0, 64'hDEAD, b[i], 64'd8);
      checks += 2;
      if (valE !== ev[i]) begin errors++; $display("FAIL stack_valE[%0d] got=%h exp=%h", i, valE, ev[i]); end
      if (cnd !== 1'b0)   begin errors++; $display("FAIL stack_cnd[%0d] got=%b exp=0", i, cnd); end
    end
  endtask

  task automatic test_cond();
    logic [3:0] ic[5] = '{4'd6, 4'd7, 4'd7, 4'd3, 4'd7};
    logic [3:0] fn[5] = '{4'd1, 4'd3, 4'd4, 4'd0, 4'd3};
    logic       ec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, ic[i], fn[i], 64'd5, 64'd5, 64'h1234);
      checks += 2;
      if (cnd !== ec[i])    begin errors++; $display("FAIL cond_cnd[%0d] got=%b exp=%b", i, cnd, ec[i]); end
      if (valE !== m_vale)  begin errors++; $display("FAIL cond_valE[%0d] got=%h exp=%h", i, valE, m_vale); end
    end
  endtask

  // Illegal codes, idle hold and mid-stream reset; CC state left by test_cond has ZF=1.
  task automatic test_illegal_reset();
    logic [W-1:0] held;
    apply(1, 1, 4'hC, 4'd0, 64'd1, 64'd2, 64'd3);
    checks += 2;
    if (flag3 !== 1'b0) begin errors++; $display("FAIL illegal_flag3 got=%b exp=0", flag3); end
    if (valE !== '0)    begin errors++; $display("FAIL illegal_valE got=%h exp=0", valE); end
    apply(1, 1, 4'd6, 4'd4, 64'd1, 64'd9, 64'd0);
    apply(1, 1, 4'd7, 4'd7, 64'd0, 64'd0, 64'd0);
    checks += 2;
    if (flag3 !== 1'b0) begin errors++; $display("FAIL illegal_jxx_flag3 got=%b exp=0", flag3); end
    if (cnd !== 1'b0)   begin errors++; $display("FAIL illegal_jxx_cnd got=%b exp=0", cnd); end
    apply(1, 1, 4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
    checks++;
    if (cnd !== 1'b1) begin errors++; $display("FAIL illegal_cc_kept got=%b exp=1", cnd); end
    apply(1, 1, 4'd3, 4'd0, 64'd0, 64'd0, 64'hABCD);
    held = valE;
    apply(1, 0, 4'd6, 4'd0, 64'd7, 64'd7, 64'd7);
    checks += 3;
    if (valE !== 64'hABCD || held !== 64'hABCD) begin errors++; $display("FAIL idle_hold got=%h exp=abcd", valE); end
    if (flag3 !== 1'b0) begin errors++; $display("FAIL idle_flag3 got=%b exp=0", flag3); end
    if (cnd !== 1'b0)   begin errors++; $display("FAIL idle_cnd got=%b exp=0", cnd); end
    apply(0, 1, 4'd3, 4'd0, 64'd0, 64'd0, 64'h77);
    checks += 3;
    if (valE !== '0)    begin errors++; $display("FAIL rst_valE got=%h exp=0", valE); end
    if (flag3 !== 1'b0) begin errors++; $display("FAIL rst_flag3 got=%b exp=0", flag3); end
    if (cnd !== 1'b0)   begin errors++; $display("FAIL rst_cnd got=%b exp=0", cnd); end
    apply(1, 1, 4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
    apply(1, 1, 4'd7, 4'd5, 64'd0, 64'd0, 64'd0);
    checks++;
    if (cnd !== 1'b1) begin errors++; $display("FAIL rst_cc_cleared got=%b exp=1", cnd); end
  endtask

  task automatic test_random();
    logic [3:0]   ic, fn;
    logic [W-1:0] a, b, c;
    logic [W-1:0] pick[4];
    pick[0] = '0;
    pick[1] = {1'b0, {(W-1){1'b1}}};
    pick[2] = {1'b1, {(W-1){1'b0}}};
    pick[3] = '1;
    for (int i = 0; i < 400; i++) begin
      ic = 4'($urandom_range(0, 15));
      if (ic > 4'd11 && $urandom_range(0, 3) != 0) ic = 4'd6;
      fn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      c = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = pick[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = pick[$urandom_range(0, 3)];
      apply(($urandom_range(0, 60) != 0), ($urandom_range(0, 4) != 0), ic, fn, a, b, c);
      checks += 3;
      if (valE !== m_vale)   begin errors++; $display("FAIL rand_valE[%0d] got=%h exp=%h", i, valE, m_vale); end
      if (cnd !== m_cnd)     begin errors++; $display("FAIL rand_cnd[%0d] got=%b exp=%b", i, cnd, m_cnd); end
      if (flag3 !== m_flag3) begin errors++; $display("FAIL rand_flag3[%0d] got=%b exp=%b", i, flag3, m_flag3); end
`ifdef EXEC_CC_PORT_EN
      checks++;
      if (cc !== {m_zf, m_sf, m_of}) begin errors++; $display("FAIL rand_cc[%0d] got=%b exp=%b", i, cc, {m_zf, m_sf, m_of}); end
`endif
    end
  endtask

  initial begin
    smax = {3'b000, {(W-1){1'b1}}};
    smin = -smax - 1;
    rst_n = 1'b0; flag2 = 1'b0; icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
    test_reset();
    test_opq();
    test_stack();
    test_cond();
    test_illegal_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
